mac_dot_engine: RTL and testbench

//  Parametrised multi-lane multiply-accumulate engine for the CNN datapath. It computes one

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_lane_sum.sv | 43 ++++
 rtl/mac_dot_engine.sv | 138 +++++++++++++
 tb/tb_mac_dot_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the multi-lane dot-product engine.
// Width helpers are evaluated at elaboration time only.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RESULT = 2'd2
  } state_e;

  function automatic int calc_len_w(input int len_max);
    return $clog2(len_max + 1);
  endfunction

  // Sized so LANES*LEN_MAX worst-case shifted products never overflow.
  function automatic int calc_acc_w(input int data_w, input int lanes,
                                    input int prod_shift, input int len_max);
    return 2 * data_w - prod_shift + $clog2(lanes * len_max);
  endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational lane multipliers, per-product right shift and pairwise adder tree.
// Zero latency; no flow control of its own.
module mac_lane_sum
  import mac_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int PROD_SHIFT = 8,
  parameter int ACC_W      = 14
) (
  input  logic [LANES*DATA_W-1:0] a_in,
  input  logic [LANES*DATA_W-1:0] b_in,
  output logic [ACC_W-1:0]        sum
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int LVLS   = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int P2     = 1 << LVLS;

  logic [ACC_W-1:0] node [LVLS+1][P2];

  always_comb begin
    logic [PROD_W-1:0] prod;
    for (int l = 0; l <= LVLS; l++) begin
      for (int j = 0; j < P2; j++) begin
        node[l][j] = '0;
      end
    end
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod       = PROD_W'(a_in[i*DATA_W +: DATA_W]) * PROD_W'(b_in[i*DATA_W +: DATA_W]);
      node[0][i] = ACC_W'(prod >> PROD_SHIFT);
    end
    // Unused leaves stay zero, so non-power-of-two lane counts fold in cleanly.
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j < (P2 >> (l + 1)); j++) begin
        node[l+1][j] = node[l][2*j] + node[l][2*j+1];
      end
    end
    sum = node[LVLS][0];
  end

endmodule

// File: rtl/mac_dot_engine.sv
// Unsigned run-time-length dot product; out_valid rises the cycle after the last accepted beat.
// Beats accepted only while accumulating; result held until out_ready. MAC_SAT_EN saturates out_data.
// Backpressure: in_ready low outside ACC, result register stalls indefinitely on out_ready=0.
module mac_dot_engine
  import mac_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int LANES      = 4,
  parameter  int PROD_SHIFT = 8,
  parameter  int LEN_MAX    = 16,
  parameter  int OUT_SHIFT  = 4,
  parameter  int OUT_W      = 8,
  localparam int LEN_W      = calc_len_w(LEN_MAX),
  localparam int ACC_W      = calc_acc_w(DATA_W, LANES, PROD_SHIFT, LEN_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a_in,
  input  logic [LANES*DATA_W-1:0] b_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy
);

  localparam int OUT_MAX = (1 << OUT_W) - 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] lane_sum;
  logic [LEN_W-1:0] len_clamped;
  logic             beat_acc;

  mac_lane_sum #(
    .DATA_W    (DATA_W),
    .LANES     (LANES),
    .PROD_SHIFT(PROD_SHIFT),
    .ACC_W     (ACC_W)
  ) u_lane_sum (
    .a_in(a_in),
    .b_in(b_in),
    .sum (lane_sum)
  );

  function automatic logic [OUT_W-1:0] scale_acc(input logic [ACC_W-1:0] acc);
`ifdef MAC_SAT_EN
    if ((acc >> OUT_SHIFT) > ACC_W'(OUT_MAX)) begin
      return '1;
    end
`endif
    return OUT_W'(acc >> OUT_SHIFT);
  endfunction

  assign len_clamped = (len > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : len;
  assign beat_acc    = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          cnt_d = '0;
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d    = RESULT;
            out_data_d = '0;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (beat_acc) begin
          acc_d = acc_q + lane_sum;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d    = RESULT;
            out_data_d = scale_acc(acc_d);
          end
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == RESULT);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Randomized scoreboard bench for mac_dot_engine with an arithmetic reference model.
module tb_mac_dot_engine;

  localparam int DATA_W  = 8;
  localparam int LANES   = 4;
  localparam int LEN_MAX = 16;
  localparam int LEN_W   = 5;
  localparam int OUT_W   = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] a_in;
  logic [LANES*DATA_W-1:0] b_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    busy;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] a_arr[LEN_MAX];
  logic [31:0] b_arr[LEN_MAX];
  bit          rdy_hold = 1'b0;
  bit          rdy_rand = 1'b0;

  always #5 clk = ~clk;

  mac_dot_engine dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Dot product straight from the arithmetic definition.
  function automatic logic [7:0] ref_result(input int n);
    longint acc;
    longint sh;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < LANES; l++) begin
        acc += (longint'(a_arr[k][8*l +: 8]) * longint'(b_arr[k][8*l +: 8])) / 256;
      end
    end
    sh = acc / 16;
`ifdef MAC_SAT_EN
    if (sh > 255) return 8'hFF;
`endif
    return 8'(sh % 256);
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: compares on every output handshake and checks hold stability.
  initial begin
    bit         hold_prev;
    logic [7:0] prev_data;
    hold_prev = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst && hold_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      hold_prev = rst && out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic start_job(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      a_arr[k] = $urandom;
      b_arr[k] = $urandom;
    end
  endtask

  task automatic fill_const(input logic [31:0] av, input logic [31:0] bv);
    for (int k = 0; k < LEN_MAX; k++) begin
      a_arr[k] = av;
      b_arr[k] = bv;
    end
  endtask

  // pat_len>0 drives in_valid from pat bits; otherwise gaps with gap_pct probability.
  task automatic feed(input int n, input int gap_pct, input logic [31:0] pat,
                      input int pat_len, input bit last_chk);
    int  k   = 0;
    int  cyc = 0;
    bit  take;
    while (k < n && cyc < 600) begin
      if (cyc < pat_len) in_valid = pat[cyc];
      else in_valid = ($urandom_range(0, 99) >= gap_pct);
      a_in = a_arr[k];
      b_in = b_arr[k];
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (take) begin
        k++;
        if (k == n && last_chk) begin
          check("latency_out_valid", 32'(out_valid), 32'd1);
          check("ready_drop", 32'(in_ready), 32'd0);
        end
      end
    end
    in_valid = 1'b0;
    check("feed_done", 32'(k), 32'(n));
  endtask

  task automatic run_job(input int l, input int gap_pct, input int exp_ovr);
    int n = (l > LEN_MAX) ? LEN_MAX : l;
    if (exp_ovr >= 0) exp_q.push_back(8'(exp_ovr));
    else exp_q.push_back(ref_result(n));
    start_job(l);
    if (n == 0) begin
      check("len0_valid", 32'(out_valid), 32'd1);
      check("len0_in_ready", 32'(in_ready), 32'd0);
    end else begin
      feed(n, gap_pct, 32'd0, 0, 1'b1);
    end
    wait_idle();
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single active lane, 0x80*0x80 each beat.
    fill_const(32'h0000_0080, 32'h0000_0080);
    run_job(16, 0, 8'h40);

    // Zero-length job.
    run_job(0, 0, 8'h00);

    // All lanes full scale.
    fill_const(32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MAC_SAT_EN
    run_job(16, 0, 8'hFF);
`else
    run_job(16, 0, 8'hF8);
`endif

    // Result held under backpressure; start pulses ignored.
    fill_random(5);
    rdy_hold = 1'b1;
    exp_q.push_back(ref_result(5));
    start_job(5);
    feed(5, 30, 32'd0, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      len   = LEN_W'(3);
      @(posedge clk);
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    start    = 1'b0;
    rdy_hold = 1'b0;
    wait_idle();
    @(posedge clk);
    #1;
    check("no_restart", 32'(busy), 32'd0);

    // Reset in the middle of a job.
    fill_random(10);
    start_job(10);
    feed(7, 0, 32'd0, 0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    fill_const(32'h4040_4040, 32'h4040_4040);
    run_job(2, 0, 8'h08);

    // Gapped beats: 1,0,1,0,0,1.
    fill_random(3);
    exp_q.push_back(ref_result(3));
    start_job(3);
    feed(3, 0, 32'b100101, 6, 1'b1);
    wait_idle();

    // Clamp of over-range length.
    fill_random(LEN_MAX);
    run_job(25, 20, -1);

    // Randomized jobs with gaps and random consumer stalls.
    rdy_rand = 1'b1;
    for (int j = 0; j < 30; j++) begin
      fill_random(LEN_MAX);
      run_job($urandom_range(0, 20), $urandom_range(0, 60), -1);
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
